capture_trigger_ctrl: RTL and testbench

Sequences single-channel phase-snapshot capture for the wavelength readout. Watches the time-multiplexed phase stream for the software-selected channel and keeps a circular pre-trigger history in a capture BRAM. Fires on a downward crossing of the software capture threshold, writes a programmed number of post-trigger samples, then freezes the buffer for PPC readout. Sits between the channelizer phase output and the capture buffer; threshold and control words come from software registers already synchronised to `user_clk`.

---
 rtl/capture_pkg.sv | 25 ++
 rtl/capture_addr_ctr.sv | 37 +++
 rtl/capture_trigger_ctrl.sv | 165 ++++++++++++++++
 tb/tb_capture_trigger_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and register field layout for the phase-snapshot capture block.
package capture_pkg;

  localparam int DATA_W_D = 16;
  localparam int CH_W_D   = 8;
  localparam int ADDR_W_D = 10;

  localparam int ARM_BIT   = 0;
  localparam int FORCE_BIT = 1;
  localparam int ABORT_BIT = 2;
  localparam int PRE_LSB   = 4;
  localparam int PRE_MSB   = 13;
  localparam int POST_LSB  = 16;
  localparam int POST_MSB  = 25;
  localparam int LEN_W     = PRE_MSB - PRE_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } cap_state_e;

endpackage

// File: rtl/capture_addr_ctr.sv
// Circular write pointer plus a loadable down-counter of remaining writes.
module capture_addr_ctr #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ptr_clr,
  input  logic              ptr_inc,
  input  logic              cnt_load,
  input  logic [CNT_W-1:0]  cnt_val,
  input  logic              cnt_dec,
  output logic [ADDR_W-1:0] ptr,
  output logic              cnt_last
);

  logic [CNT_W-1:0] cnt;

  assign cnt_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (ptr_clr)
        ptr <= '0;
      else if (ptr_inc)
        ptr <= ptr + ADDR_W'(1);
      if (cnt_load)
        cnt <= cnt_val;
      else if (cnt_dec && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Single-channel phase capture: circular pre-trigger history, threshold
// or forced trigger, fixed post-trigger length, then frozen buffer.
module capture_trigger_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CH_W   = CH_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [31:0]              thresh_reg,
  input  logic [31:0]              ctrl_reg,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [DATA_W-1:0]        buf_data,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              trig_count
);

  localparam logic [31:0] DEPTH_M1 = 32'((1 << ADDR_W) - 1);

  cap_state_e state;

  logic arm_q, force_q, force_pend, prev_v;
  logic [CH_W-1:0] ch_q;
  logic signed [DATA_W-1:0] thr_q, prev;
  logic [LEN_W-1:0] pre_in, post_in, post_eff, post_q, cnt_val;
  logic [31:0] room;
  logic arm_edge, force_edge, abort, accept, cap, wr, start, trig;
  logic cnt_load, cnt_dec, cnt_last;
  logic [ADDR_W-1:0] ptr;
  logic unused_bits;

  assign arm_edge   = ctrl_reg[ARM_BIT] & ~arm_q;
  assign force_edge = ctrl_reg[FORCE_BIT] & ~force_q;
  assign abort      = ctrl_reg[ABORT_BIT];
  assign pre_in     = ctrl_reg[PRE_MSB:PRE_LSB];
  assign post_in    = ctrl_reg[POST_MSB:POST_LSB];

  // Post length is cut so the circular write never reaches pre-trigger data.
  assign room     = DEPTH_M1 - 32'(pre_in);
  assign post_eff = (32'(post_in) > room) ? room[LEN_W-1:0] : post_in;

  assign accept = in_valid && (in_ch == ch_q);
  assign cap    = (state == S_ARMED) || (state == S_WAIT_TRIG)
                || (state == S_POST);
  assign wr     = !abort && accept && cap;
  assign start  = !abort && arm_edge
                && ((state == S_IDLE) || (state == S_DONE));
  assign trig   = wr && (state == S_WAIT_TRIG)
                && (force_pend
                    || (prev_v && prev >= thr_q && in_data < thr_q));

  assign cnt_load = start || (trig && post_q != '0);
  assign cnt_val  = start ? pre_in : post_q;
  assign cnt_dec  = wr && ((state == S_ARMED) || (state == S_POST));

  assign unused_bits = ^{thresh_reg[31:DATA_W],
                         ctrl_reg[31:POST_MSB+1],
                         ctrl_reg[POST_LSB-1:PRE_MSB+1],
                         ctrl_reg[PRE_LSB-1:ABORT_BIT+1]};

  capture_addr_ctr #(
    .ADDR_W(ADDR_W),
    .CNT_W (LEN_W)
  ) u_addr_ctr (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .ptr_clr (start),
    .ptr_inc (wr),
    .cnt_load(cnt_load),
    .cnt_val (cnt_val),
    .cnt_dec (cnt_dec),
    .ptr     (ptr),
    .cnt_last(cnt_last)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state      <= S_IDLE;
      arm_q      <= 1'b0;
      force_q    <= 1'b0;
      force_pend <= 1'b0;
      prev_v     <= 1'b0;
      prev       <= '0;
      ch_q       <= '0;
      thr_q      <= '0;
      post_q     <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      trig_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_count <= '0;
    end else begin
      arm_q   <= ctrl_reg[ARM_BIT];
      force_q <= ctrl_reg[FORCE_BIT];
      buf_we  <= 1'b0;
      if (wr) begin
        buf_we   <= 1'b1;
        buf_addr <= ptr;
        buf_data <= in_data;
        prev     <= in_data;
        prev_v   <= 1'b1;
      end
      if (state == S_WAIT_TRIG && !abort && !trig)
        force_pend <= force_pend | force_edge;
      else
        force_pend <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              ch_q   <= ch_sel;
              thr_q  <= thresh_reg[DATA_W-1:0];
              post_q <= post_eff;
              prev_v <= 1'b0;
              done   <= 1'b0;
              busy   <= 1'b1;
              state  <= (pre_in == '0) ? S_WAIT_TRIG : S_ARMED;
            end
          end
          S_ARMED: begin
            if (wr && cnt_last)
              state <= S_WAIT_TRIG;
          end
          S_WAIT_TRIG: begin
            if (trig) begin
              trig_addr  <= ptr;
              trig_count <= trig_count + 32'd1;
              if (post_q == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (wr && cnt_last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed self-checking bench for capture_trigger_ctrl.
module tb_capture_trigger_ctrl;

  localparam int DATA_W = 16;
  localparam int CH_W   = 8;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] thresh_reg = '0;
  logic [31:0] ctrl_reg = '0;
  logic [CH_W-1:0] ch_sel = '0;
  logic in_valid = 1'b0;
  logic [CH_W-1:0] in_ch = '0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] trig_addr;
  logic busy;
  logic done;
  logic [31:0] trig_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];

  capture_trigger_ctrl #(
    .DATA_W(DATA_W),
    .CH_W  (CH_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .user_clk  (clk),
    .user_rst_n(rst_n),
    .thresh_reg(thresh_reg),
    .ctrl_reg  (ctrl_reg),
    .ch_sel    (ch_sel),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .trig_addr (trig_addr),
    .busy      (busy),
    .done      (done),
    .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && buf_we) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_data);
    end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [CH_W-1:0] ch, input int d);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = DATA_W'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic arm(input int pre, input int post);
    ctrl_reg = (32'(post) << 16) | (32'(pre) << 4) | 32'd1;
    idle(2);
    ctrl_reg[0] = 1'b0;
    idle(2);
  endtask

  task automatic force_trig();
    ctrl_reg[1] = 1'b1;
    idle(2);
    ctrl_reg[1] = 1'b0;
    idle(1);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({buf_we, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {buf_we, busy, done});
    end
    n_cmp++;
    if (buf_addr !== '0 || buf_data !== '0 || trig_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%0d data=%0d trig=%0d want 0",
               buf_addr, buf_data, trig_addr);
    end
    n_cmp++;
    if (trig_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_trig_count: got %0d want 0", trig_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_threshold();
    int v[10] = '{0, 0, 0, 0, 0, -50, -150, -200, -300, -10};
    int bad = 0;
    clear_log();
    thresh_reg = 32'hFFFF_FF9C;
    ch_sel = 8'd5;
    arm(4, 3);
    ch_sel = 8'd0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL thr_busy_armed: got %b want 1", busy);
    end
    thresh_reg = 32'h0000_7000;
    for (int i = 0; i < 10; i++) begin
      smp(8'd3, -32768);
      smp(8'd5, v[i]);
    end
    idle(3);
    n_cmp++;
    if (wa_q.size() != 10) begin
      n_bad++;
      $display("FAIL thr_write_count: got %0d want 10", wa_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < 10; i++)
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== DATA_W'(v[i])) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL thr_write_seq: got %0d bad writes want 0", bad);
    end
    n_cmp++;
    if (trig_addr !== 10'd6) begin
      n_bad++;
      $display("FAIL thr_trig_addr: got %0d want 6", trig_addr);
    end
    n_cmp++;
    if (trig_count !== 32'd1) begin
      n_bad++;
      $display("FAIL thr_trig_count: got %0d want 1", trig_count);
    end
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL thr_done: got done,busy=%b want 10", {done, busy});
    end
    for (int i = 0; i < 4; i++) smp(8'd5, -500);
    idle(2);
    n_cmp++;
    if (wa_q.size() != 10) begin
      n_bad++;
      $display("FAIL thr_frozen: got %0d writes want 10", wa_q.size());
    end
  endtask

  task automatic test_force();
    clear_log();
    thresh_reg = 32'hFFFF_FF9C;
    ch_sel = 8'd5;
    arm(0, 0);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL force_armed: got busy,done=%b want 10", {busy, done});
    end
    force_trig();
    smp(8'd5, 0);
    n_cmp++;
    if ({buf_we, done} !== 2'b11 || buf_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL force_write: got we,done=%b addr=%0d want 11 addr 0",
               {buf_we, done}, buf_addr);
    end
    idle(2);
    n_cmp++;
    if (wa_q.size() != 1 || trig_addr !== 10'd0 || trig_count !== 32'd2) begin
      n_bad++;
      $display("FAIL force_result: got writes=%0d trig=%0d cnt=%0d want 1 0 2",
               wa_q.size(), trig_addr, trig_count);
    end
  endtask

  task automatic test_clamp();
    int bad = 0;
    clear_log();
    arm(1000, 100);
    for (int i = 0; i < 1000; i++) smp(8'd5, 0);
    smp(8'd5, -200);
    for (int i = 0; i < 30; i++) smp(8'd5, 7);
    idle(3);
    n_cmp++;
    if (wa_q.size() != 1024) begin
      n_bad++;
      $display("FAIL clamp_count: got %0d want 1024", wa_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < 1024; i++)
      if (wa_q[i] !== ADDR_W'(i)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL clamp_addr_seq: got %0d bad addresses want 0", bad);
    end
    n_cmp++;
    if (trig_addr !== 10'd1000 || trig_count !== 32'd3 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_trig: got addr=%0d cnt=%0d done=%b want 1000 3 1",
               trig_addr, trig_count, done);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    arm(4, 0);
    for (int i = 0; i < 3004; i++) smp(8'd5, 0);
    idle(2);
    n_cmp++;
    if (trig_count !== 32'd3 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_no_trig: got cnt=%0d busy=%b want 3 1",
               trig_count, busy);
    end
    n_cmp++;
    if (wa_q.size() != 3004 || wa_q[1024] !== 10'd0) begin
      n_bad++;
      $display("FAIL wrap_ptr: got writes=%0d wa[1024]=%0d want 3004 0",
               wa_q.size(), wa_q[1024]);
    end
    smp(8'd5, -200);
    idle(2);
    n_cmp++;
    if (trig_addr !== 10'd956 || trig_count !== 32'd4 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_trig: got addr=%0d cnt=%0d done=%b want 956 4 1",
               trig_addr, trig_count, done);
    end
  endtask

  task automatic test_abort();
    clear_log();
    arm(2, 10);
    smp(8'd5, 0);
    smp(8'd5, 0);
    smp(8'd5, -200);
    smp(8'd5, 0);
    smp(8'd5, 0);
    ctrl_reg[2] = 1'b1;
    in_valid = 1'b1;
    in_ch = 8'd5;
    in_data = '0;
    idle(2);
    ctrl_reg[2] = 1'b0;
    idle(3);
    in_valid = 1'b0;
    idle(2);
    n_cmp++;
    if (wa_q.size() != 5) begin
      n_bad++;
      $display("FAIL abort_writes: got %0d want 5", wa_q.size());
    end
    n_cmp++;
    if ({busy, done} !== 2'b00 || trig_count !== 32'd5) begin
      n_bad++;
      $display("FAIL abort_state: got busy,done=%b cnt=%0d want 00 5",
               {busy, done}, trig_count);
    end
    clear_log();
    ctrl_reg = (32'd0 << 16) | (32'd2 << 4) | 32'd5;
    idle(2);
    ctrl_reg[2] = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) smp(8'd5, 0);
    idle(2);
    n_cmp++;
    if (busy !== 1'b0 || wa_q.size() != 0) begin
      n_bad++;
      $display("FAIL arm_abort: got busy=%b writes=%0d want 0 0",
               busy, wa_q.size());
    end
    ctrl_reg = '0;
    idle(2);
  endtask

  task automatic test_async_reset();
    clear_log();
    arm(2, 10);
    smp(8'd5, 0);
    smp(8'd5, 0);
    smp(8'd5, -200);
    smp(8'd5, 0);
    n_cmp++;
    if (busy !== 1'b1 || trig_count !== 32'd6) begin
      n_bad++;
      $display("FAIL rst_pre: got busy=%b cnt=%0d want 1 6", busy, trig_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({buf_we, busy, done} !== 3'b000 || trig_count !== 32'd0
        || trig_addr !== '0 || buf_addr !== '0 || buf_data !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got we,busy,done=%b cnt=%0d trig=%0d want 000 0 0",
               {buf_we, busy, done}, trig_count, trig_addr);
    end
    ctrl_reg = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_log();
    for (int i = 0; i < 3; i++) smp(8'd5, 0);
    smp(8'd0, 0);
    idle(2);
    n_cmp++;
    if ({busy, done} !== 2'b00 || wa_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_idle: got busy,done=%b writes=%0d want 00 0",
               {busy, done}, wa_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_force();
    test_clamp();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
